spi_audio_tx: RTL and testbench
===============================

Name: spi_audio_tx

Overview:
SPI master transmitter that serialises 16-bit processed audio samples out of the FPGA. It is the transmit-side counterpart of the comunication SPI receiver: it drives SCLK, MOSI and a frame-active line in mode 0, MSB first. It sits after the effect path and output mux in top, and is fed by the same data_ready/sample strobe style. A one-deep pending register absorbs a sample that arrives during a frame.

Parameters:
clock_max, 25_000_000, system clock frequency in Hz; informational, used only for the SCLK rate assertion.
SCLK_DIV, 4, SCLK half-period in clk_25mhz cycles; must be >= 1. Default gives 3.125 MHz.
CS_SETUP, 2, cycles active_out is high before the first SCLK rising edge; must be >= 1.
CS_HOLD, 2, cycles active_out stays high after the last SCLK falling edge; must be >= 1.
IDLE_GAP, 2, minimum cycles active_out is low between frames; must be >= 1.

Ports:
clk_25mhz  input  1  system clock
reset  input  1  asynchronous, active-low reset
data_ready  input  1  one-cycle strobe; audio_in is valid in this cycle
audio_in  input  16  sample to transmit
sclk_out  output  1  SPI clock; idles low (CPOL=0)
mosi_out  output  1  serial data, MSB first; sampled by the slave on the SCLK rising edge
active_out  output  1  frame enable, high for the whole frame
busy  output  1  high from frame start until the return to IDLE
tx_done  output  1  one-cycle pulse at the end of HOLD
overrun  output  1  one-cycle pulse when a queued sample is overwritten

Behaviour:
- Reset asserted (reset=0), asynchronous: state=IDLE; sclk_out, mosi_out, active_out, busy, tx_done and overrun are all 0; the pending register is cleared.
- All outputs are registered.
- State machine:
  - IDLE -> SETUP on data_ready. The sample loads into the shift register.
  - SETUP: lasts CS_SETUP cycles; active_out=1, sclk_out=0, mosi_out=bit15.
  - SHIFT: 16 bits. Each bit is SCLK_DIV cycles low, then SCLK_DIV cycles high.
  - mosi_out advances to the next bit on the cycle sclk falls, so it is stable across each rising edge.
  - SHIFT -> HOLD after the 16th high half-period ends; sclk_out returns to 0.
  - HOLD: lasts CS_HOLD cycles with active_out=1; tx_done pulses on its last cycle.
  - GAP: lasts IDLE_GAP cycles with active_out=0.
  - From GAP: if the pending register is valid, load it, clear pending and go to SETUP; otherwise go to IDLE.
- Latency: data_ready in IDLE at cycle N gives active_out=1 at N+1.
- Frame length: CS_SETUP + 32*SCLK_DIV + CS_HOLD cycles. Frame-to-frame period adds IDLE_GAP; default period is 134 cycles.
- data_ready while not IDLE:
  - pending empty: the sample is stored in pending.
  - pending full: the sample overwrites pending and overrun pulses in the next cycle.
  - The in-flight frame is never disturbed.
- data_ready in the same cycle GAP exits: the incoming sample goes to pending if pending was empty. If pending was full, the loaded sample transmits and the incoming one becomes the new pending, with no overrun.
- busy=1 in every state except IDLE.
- Counters: bit counter is 4 bits and wraps 15->0 only at the SHIFT exit. The half-period counter is sized $clog2(SCLK_DIV+1).
- Elaboration assertions: SCLK_DIV, CS_SETUP, CS_HOLD and IDLE_GAP are all >= 1; clock_max/(2*SCLK_DIV) <= 12_500_000.

Decomposition:
- Package audio_pkg holds:
  - sample_t (logic [15:0])
  - the tx_state_t enum {IDLE, SETUP, SHIFT, HOLD, GAP}
  - localparam DEFAULT_CLOCK_MAX = 25_000_000
  - localparam SAMPLE_W = 16
- Sub-module spi_half_tick: a counter that emits a one-cycle tick every SCLK_DIV cycles while enabled, cleared when not enabled. The FSM toggles SCLK on each tick.

Test Plan:
1. reset=0 for 5 cycles, then release; one data_ready with 16'hA5C3 -> mosi sampled on 16 rising edges reads 1010_0101_1100_0011. active_out is high for 132 cycles, tx_done pulses once, busy falls at cycle 135.
2. Two strobes 16'h0001 then 16'h8000, 10 cycles apart -> two frames with exactly IDLE_GAP=2 low cycles of active_out between them; no overrun.
3. Three strobes 16'h1111, 16'h2222, 16'h3333 within the first frame -> overrun pulses once. Transmitted frames are 1111 then 3333; 2222 is never sent.
4. reset=0 asserted mid-SHIFT at bit 7 -> same cycle, sclk_out, mosi_out and active_out are 0. After release, a strobe with 16'hFFFF produces a clean full frame.
5. SCLK_DIV=1, samples 16'h0000 and 16'hFFFF -> SCLK period is 2 cycles, frame length is 36 cycles, and mosi is constant across each frame.
6. data_ready in the exact GAP-exit cycle with pending full (16'hAAAA queued, incoming 16'h5555) -> no overrun. AAAA is transmitted next, then 5555.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared sample type, transmitter state encoding and constants
package audio_pkg;
  localparam int DEFAULT_CLOCK_MAX = 25_000_000;
  localparam int SAMPLE_W = 16;
  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} tx_state_t;
endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick: one-cycle tick every DIV enabled cycles; counter clears while disabled
module spi_half_tick #(
  parameter int DIV = 4
) (
  input  logic clk_25mhz,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(DIV + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = en && (cnt_q == W'(DIV - 1));
    cnt_d = (en && !tick) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk_25mhz or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/spi_audio_tx.sv
// spi_audio_tx: mode-0 SPI master shifting 16-bit audio samples out MSB first,
// with a one-deep pending register for samples that arrive mid-frame.
module spi_audio_tx
  import audio_pkg::*;
#(
  parameter int clock_max = DEFAULT_CLOCK_MAX,
  parameter int SCLK_DIV  = 4,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int IDLE_GAP  = 2
) (
  input  logic                clk_25mhz,
  input  logic                reset,
  input  logic                data_ready,
  input  logic [SAMPLE_W-1:0] audio_in,
  output logic                sclk_out,
  output logic                mosi_out,
  output logic                active_out,
  output logic                busy,
  output logic                tx_done,
  output logic                overrun
);
  localparam int MAX_SH = CS_SETUP > CS_HOLD ? CS_SETUP : CS_HOLD;
  localparam int MAXC = MAX_SH > IDLE_GAP ? MAX_SH : IDLE_GAP;
  localparam int CW = $clog2(MAXC + 1);
  localparam int DIV_SAFE = SCLK_DIV < 1 ? 1 : SCLK_DIV;

  if (SCLK_DIV < 1 || CS_SETUP < 1 || CS_HOLD < 1 || IDLE_GAP < 1) begin : g_bad_timing
    $error("spi_audio_tx: SCLK_DIV, CS_SETUP, CS_HOLD and IDLE_GAP must all be >= 1");
  end
  if (clock_max / (2 * DIV_SAFE) > 12_500_000) begin : g_bad_rate
    $error("spi_audio_tx: SCLK rate exceeds 12.5 MHz");
  end

  tx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  sample_t shift_q, shift_d, pend_q, pend_d;
  logic pend_v_q, pend_v_d, sclk_q, sclk_d, active_q, active_d;
  logic busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
  logic tick, gap_exit, consume, store;

  spi_half_tick #(.DIV(SCLK_DIV)) u_tick (
    .clk_25mhz(clk_25mhz),
    .reset    (reset),
    .en       (state_q == SHIFT),
    .tick     (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    shift_d = shift_q;
    sclk_d = sclk_q;
    pend_d = pend_q;
    pend_v_d = pend_v_q;
    gap_exit = state_q == GAP && cnt_q == CW'(IDLE_GAP - 1);
    consume = pend_v_q && (gap_exit || state_q == IDLE);
    store = data_ready && (state_q != IDLE || pend_v_q);
    case (state_q)
      IDLE: if (pend_v_q || data_ready) begin
        state_d = SETUP;
        shift_d = pend_v_q ? pend_q : audio_in;
        cnt_d = '0;
      end
      SETUP: begin
        state_d = cnt_q == CW'(CS_SETUP - 1) ? SHIFT : SETUP;
        cnt_d = cnt_q == CW'(CS_SETUP - 1) ? '0 : cnt_q + 1'b1;
      end
      SHIFT: if (tick) begin
        sclk_d = !sclk_q;
        // Rotating (not shifting) leaves mosi on the sample MSB once the frame ends.
        if (sclk_q) begin
          shift_d = {shift_q[14:0], shift_q[15]};
          bit_d = bit_q + 1'b1;
          state_d = bit_q == 4'd15 ? HOLD : SHIFT;
        end
      end
      HOLD: begin
        state_d = cnt_q == CW'(CS_HOLD - 1) ? GAP : HOLD;
        cnt_d = cnt_q == CW'(CS_HOLD - 1) ? '0 : cnt_q + 1'b1;
      end
      GAP: if (gap_exit) begin
        state_d = pend_v_q ? SETUP : IDLE;
        shift_d = pend_v_q ? pend_q : shift_q;
        cnt_d = '0;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    if (consume) pend_v_d = 1'b0;
    if (store) begin
      pend_d = audio_in;
      pend_v_d = 1'b1;
    end
    ovr_d = store && pend_v_q && !consume;
    done_d = state_d == HOLD && cnt_d == CW'(CS_HOLD - 1);
    active_d = state_d inside {SETUP, SHIFT, HOLD};
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk_25mhz or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      pend_q <= '0;
      pend_v_q <= 1'b0;
      sclk_q <= 1'b0;
      active_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      pend_q <= pend_d;
      pend_v_q <= pend_v_d;
      sclk_q <= sclk_d;
      active_q <= active_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovr_q <= ovr_d;
    end

  assign sclk_out = sclk_q;
  assign mosi_out = shift_q[15];
  assign active_out = active_q;
  assign busy = busy_q;
  assign tx_done = done_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_spi_audio_tx.sv
`timescale 1ns/1ps
// tb_spi_audio_tx: directed and randomized checks of spi_audio_tx against a frame-level model
module tb_spi_audio_tx;
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic dr [2];
  logic [15:0] din [2];
  logic sclk [2], mosi [2], act [2], bsy [2], done [2], ovr [2];
  int cyc = 0, n_chk = 0, n_fail = 0;

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_audio_tx dut0 (
    .clk_25mhz(clk), .reset(rst_n), .data_ready(dr[0]), .audio_in(din[0]),
    .sclk_out(sclk[0]), .mosi_out(mosi[0]), .active_out(act[0]),
    .busy(bsy[0]), .tx_done(done[0]), .overrun(ovr[0])
  );

  spi_audio_tx #(.SCLK_DIV(1)) dut1 (
    .clk_25mhz(clk), .reset(rst_n), .data_ready(dr[1]), .audio_in(din[1]),
    .sclk_out(sclk[1]), .mosi_out(mosi[1]), .active_out(act[1]),
    .busy(bsy[1]), .tx_done(done[1]), .overrun(ovr[1])
  );

  // Per instance: a frame-timing model fed by the stimulus, and a pin-level frame decoder.
  for (genvar g = 0; g < 2; g++) begin : m
    localparam int D = g == 0 ? 4 : 1;
    localparam int PER = 2 + 32 * D + 2 + 2;
    logic [15:0] exp_w [$], got_w [$];
    int exp_s [$], got_s [$], got_len [$], got_gap [$];
    bit got_var [$];
    int exp_ovr, got_ovr, got_done, done_cyc, bad_nb, per_err;
    int free_at, exit_at, start, last_end, nb, last_rise;
    logic pv, pa, ps, pmo, fv;
    logic [15:0] pd, sh;
    initial begin
      exp_ovr = 0; got_ovr = 0; got_done = 0; done_cyc = -1; bad_nb = 0; per_err = 0;
      free_at = 0; exit_at = -1; start = 0; last_end = -1; nb = 0; last_rise = 0;
      pv = 0; pa = 0; ps = 0; pmo = 0; fv = 0; pd = 0; sh = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          free_at = 0; exit_at = -1; pv = 0; pa = 0; ps = 0; last_end = -1;
        end else begin
          if (clr) begin
            exp_w.delete(); got_w.delete(); exp_s.delete(); got_s.delete();
            got_len.delete(); got_gap.delete(); got_var.delete();
            exp_ovr = 0; got_ovr = 0; got_done = 0; done_cyc = -1; bad_nb = 0; per_err = 0;
            last_end = -1;
          end
          if (pv && (cyc >= free_at || cyc == exit_at)) begin
            exp_w.push_back(pd); exp_s.push_back(cyc + 1);
            exit_at = cyc + PER; free_at = exit_at + 1; pv = 0;
          end
          if (dr[g]) begin
            if (cyc >= free_at) begin
              exp_w.push_back(din[g]); exp_s.push_back(cyc + 1);
              exit_at = cyc + PER; free_at = exit_at + 1;
            end else begin
              exp_ovr += int'(pv); pv = 1; pd = din[g];
            end
          end
          if (act[g] && !pa) begin
            start = cyc; nb = 0; sh = 0; fv = 0; got_s.push_back(cyc);
            if (last_end >= 0) got_gap.push_back(cyc - last_end);
          end
          if (act[g] && pa && mosi[g] !== pmo) fv = 1;
          if (act[g] && sclk[g] && !ps) begin
            if (nb > 0 && cyc - last_rise != 2 * D) per_err++;
            sh = {sh[14:0], mosi[g]}; nb++; last_rise = cyc;
          end
          if (!act[g] && pa) begin
            got_w.push_back(sh); got_len.push_back(cyc - start); got_var.push_back(fv);
            if (nb != 16) bad_nb++;
            last_end = cyc;
          end
          if (done[g]) begin got_done++; done_cyc = cyc; end
          if (ovr[g]) got_ovr++;
          pa = act[g]; ps = sclk[g]; pmo = mosi[g];
        end
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic go_to(input int target);
    while (cyc < target) cyc_wait(1);
  endtask

  task automatic strobe(input int g, input logic [15:0] v);
    dr[g] = 1'b1; din[g] = v;
    cyc_wait(1);
    dr[g] = 1'b0;
  endtask

  task automatic flush();
    clr = 1'b1; cyc_wait(1); clr = 1'b0;
  endtask

  task automatic settle(input int g, output bit ok);
    int quiet = 0;
    ok = 0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      cyc_wait(1);
      quiet = bsy[g] ? 0 : quiet + 1;
      ok = quiet >= 3;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc_wait(5);
    for (int g = 0; g < 2; g++) begin
      n_chk++;
      if ({sclk[g], mosi[g], act[g], bsy[g], done[g], ovr[g]} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got %b expected 000000", g,
                 {sclk[g], mosi[g], act[g], bsy[g], done[g], ovr[g]});
      end
    end
    rst_n = 1'b1;
    cyc_wait(2);
  endtask

  task automatic test_single();
    int t, fall = 0;
    bit ok;
    flush();
    t = cyc; strobe(0, 16'hA5C3);
    for (int k = 0; k < 400 && fall == 0; k++) if (!bsy[0]) fall = cyc; else cyc_wait(1);
    settle(0, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_settle: busy never returned low"); end
    n_chk++; if (m[0].got_w.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d frames expected 1", m[0].got_w.size()); end
    n_chk++; if (m[0].got_w[0] !== 16'hA5C3) begin n_fail++; $display("FAIL single_word: got %h expected a5c3", m[0].got_w[0]); end
    n_chk++; if (m[0].got_len[0] != 132) begin n_fail++; $display("FAIL single_len: got %0d expected 132", m[0].got_len[0]); end
    n_chk++; if (m[0].got_s[0] != t + 1) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", m[0].got_s[0], t + 1); end
    n_chk++; if (fall != t + 135) begin n_fail++; $display("FAIL single_busy_fall: got %0d expected %0d", fall, t + 135); end
    n_chk++; if (m[0].got_done != 1 || m[0].done_cyc != t + 132) begin n_fail++; $display("FAIL single_tx_done: got %0d pulses at %0d expected 1 at %0d", m[0].got_done, m[0].done_cyc, t + 132); end
    n_chk++; if (m[0].bad_nb != 0 || m[0].per_err != 0 || m[0].got_ovr != 0) begin n_fail++; $display("FAIL single_shape: bad_bits %0d bad_period %0d overrun %0d expected all 0", m[0].bad_nb, m[0].per_err, m[0].got_ovr); end
  endtask

  task automatic test_back_to_back();
    int t;
    bit ok;
    flush();
    t = cyc; strobe(0, 16'h0001);
    go_to(t + 10); strobe(0, 16'h8000);
    settle(0, ok);
    n_chk++; if (!ok || m[0].got_w.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d frames expected 2", m[0].got_w.size()); end
    n_chk++; if (m[0].got_w[0] !== 16'h0001 || m[0].got_w[1] !== 16'h8000) begin n_fail++; $display("FAIL b2b_words: got %h %h expected 0001 8000", m[0].got_w[0], m[0].got_w[1]); end
    n_chk++; if (m[0].got_gap[0] != 2) begin n_fail++; $display("FAIL b2b_gap: got %0d expected 2", m[0].got_gap[0]); end
    n_chk++; if (m[0].got_s[1] != t + 135) begin n_fail++; $display("FAIL b2b_start: got %0d expected %0d", m[0].got_s[1], t + 135); end
    n_chk++; if (m[0].got_ovr != 0) begin n_fail++; $display("FAIL b2b_overrun: got %0d expected 0", m[0].got_ovr); end
  endtask

  task automatic test_overrun();
    int t;
    bit ok;
    flush();
    t = cyc; strobe(0, 16'h1111);
    go_to(t + 10); strobe(0, 16'h2222);
    go_to(t + 20); strobe(0, 16'h3333);
    settle(0, ok);
    n_chk++; if (!ok || m[0].got_w.size() != 2) begin n_fail++; $display("FAIL ovr_count: got %0d frames expected 2", m[0].got_w.size()); end
    n_chk++; if (m[0].got_w[0] !== 16'h1111 || m[0].got_w[1] !== 16'h3333) begin n_fail++; $display("FAIL ovr_words: got %h %h expected 1111 3333", m[0].got_w[0], m[0].got_w[1]); end
    n_chk++; if (m[0].got_ovr != 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", m[0].got_ovr); end
  endtask

  task automatic test_reset_mid();
    int t;
    bit ok;
    flush();
    t = cyc; strobe(0, 16'hFFFF);
    go_to(t + 63);
    n_chk++; if (sclk[0] !== 1'b1 || act[0] !== 1'b1 || mosi[0] !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got sclk %b act %b mosi %b expected 1 1 1", sclk[0], act[0], mosi[0]); end
    rst_n = 1'b0;
    #1;
    n_chk++; if ({sclk[0], mosi[0], act[0]} !== 3'b0) begin n_fail++; $display("FAIL mid_async_reset: got %b expected 000", {sclk[0], mosi[0], act[0]}); end
    cyc_wait(3); rst_n = 1'b1; cyc_wait(2);
    flush();
    strobe(0, 16'hFFFF);
    settle(0, ok);
    n_chk++; if (!ok || m[0].got_w.size() != 1 || m[0].got_w[0] !== 16'hFFFF) begin n_fail++; $display("FAIL mid_recover_word: got %0d frames first %h expected 1 frame ffff", m[0].got_w.size(), m[0].got_w[0]); end
    n_chk++; if (m[0].got_len[0] != 132 || m[0].bad_nb != 0) begin n_fail++; $display("FAIL mid_recover_shape: got len %0d bad_bits %0d expected 132 0", m[0].got_len[0], m[0].bad_nb); end
  endtask

  task automatic test_fast_div();
    int t;
    bit ok;
    flush();
    t = cyc; strobe(1, 16'h0000);
    go_to(t + 5); strobe(1, 16'hFFFF);
    settle(1, ok);
    n_chk++; if (!ok || m[1].got_w.size() != 2) begin n_fail++; $display("FAIL fast_count: got %0d frames expected 2", m[1].got_w.size()); end
    n_chk++; if (m[1].got_w[0] !== 16'h0000 || m[1].got_w[1] !== 16'hFFFF) begin n_fail++; $display("FAIL fast_words: got %h %h expected 0000 ffff", m[1].got_w[0], m[1].got_w[1]); end
    n_chk++; if (m[1].got_len[0] != 36 || m[1].got_len[1] != 36) begin n_fail++; $display("FAIL fast_len: got %0d %0d expected 36 36", m[1].got_len[0], m[1].got_len[1]); end
    n_chk++; if (m[1].per_err != 0 || m[1].bad_nb != 0) begin n_fail++; $display("FAIL fast_period: bad_period %0d bad_bits %0d expected 0 0", m[1].per_err, m[1].bad_nb); end
    n_chk++; if (m[1].got_var[0] || m[1].got_var[1]) begin n_fail++; $display("FAIL fast_mosi_const: got varying %b %b expected 0 0", m[1].got_var[0], m[1].got_var[1]); end
    n_chk++; if (m[1].got_s[1] != t + 39) begin n_fail++; $display("FAIL fast_start: got %0d expected %0d", m[1].got_s[1], t + 39); end
  endtask

  task automatic test_gap_exit();
    int t;
    bit ok;
    flush();
    t = cyc; strobe(0, 16'h1234);
    go_to(t + 10); strobe(0, 16'hAAAA);
    go_to(t + 134); strobe(0, 16'h5555);
    settle(0, ok);
    n_chk++; if (!ok || m[0].got_w.size() != 3) begin n_fail++; $display("FAIL gapx_count: got %0d frames expected 3", m[0].got_w.size()); end
    n_chk++; if (m[0].got_w[1] !== 16'hAAAA || m[0].got_w[2] !== 16'h5555) begin n_fail++; $display("FAIL gapx_words: got %h %h expected aaaa 5555", m[0].got_w[1], m[0].got_w[2]); end
    n_chk++; if (m[0].got_ovr != 0) begin n_fail++; $display("FAIL gapx_overrun: got %0d expected 0", m[0].got_ovr); end
    n_chk++; if (m[0].got_s[1] != t + 135 || m[0].got_s[2] != t + 269) begin n_fail++; $display("FAIL gapx_starts: got %0d %0d expected %0d %0d", m[0].got_s[1], m[0].got_s[2], t + 135, t + 269); end
  endtask

  task automatic test_random();
    bit ok;
    int n, bad_len = 0, bad_gap = 0;
    flush();
    for (int i = 0; i < 30; i++) begin
      strobe(0, 16'($urandom));
      cyc_wait($urandom_range(0, 170));
    end
    settle(0, ok);
    n_chk++; if (!ok || m[0].got_w.size() != m[0].exp_w.size()) begin n_fail++; $display("FAIL rand_count: got %0d frames expected %0d", m[0].got_w.size(), m[0].exp_w.size()); end
    n = m[0].got_w.size() < m[0].exp_w.size() ? m[0].got_w.size() : m[0].exp_w.size();
    for (int i = 0; i < n; i++) begin
      n_chk++; if (m[0].got_w[i] !== m[0].exp_w[i]) begin n_fail++; $display("FAIL rand_word[%0d]: got %h expected %h", i, m[0].got_w[i], m[0].exp_w[i]); end
      n_chk++; if (m[0].got_s[i] != m[0].exp_s[i]) begin n_fail++; $display("FAIL rand_start[%0d]: got %0d expected %0d", i, m[0].got_s[i], m[0].exp_s[i]); end
      if (m[0].got_len[i] != 132) bad_len++;
    end
    foreach (m[0].got_gap[i]) if (m[0].got_gap[i] < 2) bad_gap++;
    n_chk++; if (m[0].got_ovr != m[0].exp_ovr) begin n_fail++; $display("FAIL rand_overrun: got %0d expected %0d", m[0].got_ovr, m[0].exp_ovr); end
    n_chk++; if (m[0].got_done != m[0].exp_w.size()) begin n_fail++; $display("FAIL rand_tx_done: got %0d expected %0d", m[0].got_done, m[0].exp_w.size()); end
    n_chk++; if (bad_len != 0 || bad_gap != 0 || m[0].bad_nb != 0 || m[0].per_err != 0) begin n_fail++; $display("FAIL rand_shape: bad_len %0d bad_gap %0d bad_bits %0d bad_period %0d expected all 0", bad_len, bad_gap, m[0].bad_nb, m[0].per_err); end
  endtask

  initial begin
    dr[0] = 1'b0; dr[1] = 1'b0; din[0] = '0; din[1] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_fast_div();
    test_gap_exit();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time bound exceeded");
    $fatal(1);
  end
endmodule
